// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute/writeback stage: opcodes, FSM
// state encoding and default widths.
package alu_exec_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_MUL = 1'b1
   } state_t;

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative shift-add multiplier: one partial product per cycle while run
// is high; done flags the final iteration and product already includes it.
module alu_exec_mul
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              run,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  cnt;

   // Accumulator value after this cycle's partial product; truncated to DATA_W.
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = run && (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (run) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Single-issue execute/writeback stage in front of the 8x8 register file:
// D slot reads operands, W slot drives the write port one cycle later.
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_rs0,
   input  logic [ADDR_W-1:0] instr_rs1,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [ADDR_W-1:0] rf_read_addr0,
   output logic [ADDR_W-1:0] rf_read_addr1,
   input  logic [DATA_W-1:0] rf_read_data0,
   input  logic [DATA_W-1:0] rf_read_data1,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_enable,
   output logic              busy,
   output logic              flag_zero
);

   state_t            state;

   logic              vld_p1;
   logic [2:0]        op_p1;
   logic [ADDR_W-1:0] rd_p1;
   logic [ADDR_W-1:0] rs0_p1;
   logic [ADDR_W-1:0] rs1_p1;
   logic [DATA_W-1:0] imm_p1;

   logic              vld_p2;
   logic [ADDR_W-1:0] addr_p2;
   logic [DATA_W-1:0] data_p2;

   logic              accept;
   logic              alu_fire;
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] mul_product;

   function automatic logic [DATA_W-1:0] alu_eval(
      input logic [2:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] imm
   );
      logic [DATA_W-1:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_LDI:  r = imm;
         OP_SHL:  r = a << b[2:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   assign instr_ready = !vld_p1 || (state == ST_RUN && op_p1 != OP_MUL);
   assign accept      = instr_valid && instr_ready;
   assign alu_fire    = (state == ST_RUN) && vld_p1 && (op_p1 != OP_MUL);
   assign mul_start   = (state == ST_RUN) && vld_p1 && (op_p1 == OP_MUL);
   assign busy        = (state == ST_MUL);

   assign rf_read_addr0 = vld_p1 ? rs0_p1 : '0;
   assign rf_read_addr1 = vld_p1 ? rs1_p1 : '0;
   assign alu_res       = alu_eval(op_p1, rf_read_data0, rf_read_data1, imm_p1);

   assign rf_write_enable = vld_p2;
   assign rf_write_addr   = addr_p2;
   assign rf_write_data   = data_p2;

   alu_exec_mul #(
      .DATA_W(DATA_W)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mul_start),
      .run    (busy),
      .a      (rf_read_data0),
      .b      (rf_read_data1),
      .done   (mul_done),
      .product(mul_product)
   );

   // D -> W boundary: FSM, writeback register and D-slot refill share one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         vld_p1    <= 1'b0;
         op_p1     <= '0;
         rd_p1     <= '0;
         rs0_p1    <= '0;
         rs1_p1    <= '0;
         imm_p1    <= '0;
         vld_p2    <= 1'b0;
         addr_p2   <= '0;
         data_p2   <= '0;
         flag_zero <= 1'b0;
      end else begin
         vld_p2 <= 1'b0;
         if (alu_fire) begin
            vld_p2    <= 1'b1;
            addr_p2   <= rd_p1;
            data_p2   <= alu_res;
            flag_zero <= (alu_res == '0);
         end else if (mul_start) begin
            state <= ST_MUL;
         end else if (mul_done) begin
            vld_p2    <= 1'b1;
            addr_p2   <= rd_p1;
            data_p2   <= mul_product;
            flag_zero <= (mul_product == '0);
            state     <= ST_RUN;
         end

         if (accept) begin
            vld_p1 <= 1'b1;
            op_p1  <= instr_op;
            rd_p1  <= instr_rd;
            rs0_p1 <= instr_rs0;
            rs1_p1 <= instr_rs1;
            imm_p1 <= instr_imm;
         end else if (alu_fire || mul_done) begin
            vld_p1 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: forwarding register file model, architectural
// reference model with a queue of expected writes, directed and random steps.
module tb_alu_exec_stage;
   import alu_exec_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [2:0] instr_rd;
   logic [2:0] instr_rs0;
   logic [2:0] instr_rs1;
   logic [7:0] instr_imm;
   logic [2:0] rf_read_addr0;
   logic [2:0] rf_read_addr1;
   logic [7:0] rf_read_data0;
   logic [7:0] rf_read_data1;
   logic [2:0] rf_write_addr;
   logic [7:0] rf_write_data;
   logic       rf_write_enable;
   logic       busy;
   logic       flag_zero;

   alu_exec_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_op       (instr_op),
      .instr_rd       (instr_rd),
      .instr_rs0      (instr_rs0),
      .instr_rs1      (instr_rs1),
      .instr_imm      (instr_imm),
      .rf_read_addr0  (rf_read_addr0),
      .rf_read_addr1  (rf_read_addr1),
      .rf_read_data0  (rf_read_data0),
      .rf_read_data1  (rf_read_data1),
      .rf_write_addr  (rf_write_addr),
      .rf_write_data  (rf_write_data),
      .rf_write_enable(rf_write_enable),
      .busy           (busy),
      .flag_zero      (flag_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file with same-cycle write-through forwarding.
   logic [7:0] rf_mem [8];
   logic       rf_clr;

   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
      end else if (rf_write_enable) begin
         rf_mem[rf_write_addr] <= rf_write_data;
      end
   end

   always_comb begin
      rf_read_data0 = rf_mem[rf_read_addr0];
      rf_read_data1 = rf_mem[rf_read_addr1];
      if (rf_write_enable && rf_write_addr == rf_read_addr0) rf_read_data0 = rf_write_data;
      if (rf_write_enable && rf_write_addr == rf_read_addr1) rf_read_data1 = rf_write_data;
   end

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
      int         due;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] arch [8];
   int         n_pass  = 0;
   int         n_total = 0;
   int         edge_n  = 0;
   int         mul_acc = -100;
   int         acc_edge = 0;
   logic       last_acc = 1'b0;

   function automatic logic [7:0] ref_alu(input int op, input int a, input int b, input int imm);
      int r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = imm;
         6: r = a << (b % 8);
         default: r = a * b;
      endcase
      return r[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock: update the model for an accepting edge, then check the cycle after it.
   task automatic tick();
      int         e;
      logic       acc;
      logic [7:0] res;
      e   = edge_n;
      acc = rst_n && instr_valid && instr_ready;
      last_acc = acc;
      if (acc) begin
         res = ref_alu(int'(instr_op), int'(arch[instr_rs0]), int'(arch[instr_rs1]), int'(instr_imm));
         arch[instr_rd] = res;
         exp_q.push_back('{instr_rd, res, (instr_op == OP_MUL) ? e + 9 : e + 1});
         if (instr_op == OP_MUL) mul_acc = e;
         acc_edge = e;
      end
      @(posedge clk);
      #1;
      edge_n++;
      check("instr_ready", instr_ready, !(e >= mul_acc && e <= mul_acc + 8));
      check("busy", busy, (e >= mul_acc + 1 && e <= mul_acc + 8));
      if (exp_q.size() > 0 && exp_q[0].due == e) begin
         check("write_enable", rf_write_enable, 1'b1);
         check("write_addr", rf_write_addr, exp_q[0].addr);
         check("write_data", rf_write_data, exp_q[0].data);
         check("flag_zero", flag_zero, (exp_q[0].data == 8'h00));
         void'(exp_q.pop_front());
      end else begin
         check("no_write", rf_write_enable, 1'b0);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs0,
                        input logic [2:0] rs1, input logic [7:0] imm);
      int k;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs0   = rs0;
      instr_rs1   = rs1;
      instr_imm   = imm;
      instr_valid = 1'b1;
      k = 0;
      last_acc = 1'b0;
      while (!last_acc && k < 30) begin
         tick();
         k++;
      end
      if (!last_acc) check("issue_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      instr_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, instr_ready, 1'b1);
      check({tag, "_we"}, rf_write_enable, 1'b0);
      check({tag, "_waddr"}, rf_write_addr, 3'd0);
      check({tag, "_wdata"}, rf_write_data, 8'h00);
      check({tag, "_raddr0"}, rf_read_addr0, 3'd0);
      check({tag, "_raddr1"}, rf_read_addr1, 3'd0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_flag"}, flag_zero, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e1, e2, e3, em, ea;
      rst_n       = 1'b0;
      rf_clr      = 1'b1;
      instr_valid = 1'b1;
      instr_op    = OP_ADD;
      instr_rd    = 3'd1;
      instr_rs0   = 3'd2;
      instr_rs1   = 3'd3;
      instr_imm   = 8'hA5;

      // Reset held with an instruction offered
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      instr_valid = 1'b0;
      rf_clr      = 1'b0;
      rst_n       = 1'b1;
      for (int i = 0; i < 8; i++) arch[i] = 8'h00;
      drain(3);

      // Back-to-back throughput with forwarding
      issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05);
      e1 = acc_edge;
      issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03);
      e2 = acc_edge;
      issue(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
      e3 = acc_edge;
      check("b2b_accept_1", e2 - e1, 1);
      check("b2b_accept_2", e3 - e2, 1);
      drain(3);
      check("add_r3", rf_mem[3], 8'h08);

      // Wrap, zero flag, shift
      issue(OP_SUB, 3'd4, 3'd2, 3'd1, 8'h00);
      issue(OP_XOR, 3'd5, 3'd1, 3'd1, 8'h00);
      issue(OP_SHL, 3'd6, 3'd1, 3'd2, 8'h00);
      drain(3);
      check("sub_r4", rf_mem[4], 8'hFE);
      check("xor_r5", rf_mem[5], 8'h00);
      check("shl_r6", rf_mem[6], 8'h28);

      // Multiply stall with the next instruction held valid
      issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0D);
      issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h0B);
      issue(OP_MUL, 3'd7, 3'd1, 3'd2, 8'h00);
      em = acc_edge;
      issue(OP_ADD, 3'd0, 3'd1, 3'd2, 8'h00);
      ea = acc_edge;
      check("mul_next_accept", ea - em, 10);
      drain(3);
      check("mul_r7", rf_mem[7], 8'h8F);
      check("add_r0", rf_mem[0], 8'h18);

      // Multiply truncation
      issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hFF);
      issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hFF);
      issue(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h00);
      drain(12);
      check("mul_trunc_r6", rf_mem[6], 8'h01);

      // Reset in cycle 5 of a multiply
      issue(OP_MUL, 3'd5, 3'd1, 3'd2, 8'h00);
      repeat (4) tick();
      check("mid_mul_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_mul");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      edge_n += 2;
      exp_q.delete();
      mul_acc = -100;
      for (int i = 0; i < 8; i++) arch[i] = rf_mem[i];
      check_reset_outputs("after_release");
      drain(12);
      check("mid_mul_no_write", rf_mem[5], 8'h00);

      // Random instruction stream against the reference model
      for (int n = 0; n < 300; n++) begin
         instr_valid = ($urandom_range(3) != 0);
         instr_op    = 3'($urandom_range(7));
         instr_rd    = 3'($urandom_range(7));
         instr_rs0   = 3'($urandom_range(7));
         instr_rs1   = 3'($urandom_range(7));
         instr_imm   = 8'($urandom_range(255));
         tick();
      end
      drain(12);
      check("queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 8; i++) check("final_rf", rf_mem[i], arch[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
